// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, operation encodings and the arbiter state type.
// Imported by the alu, execute_alu and alu_arbiter.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NONE = 5'd0,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ZERO = '0;

  typedef enum logic {
    ARB_IDLE,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// winner and wraps, so every continuously requesting input is served in turn.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with a round-robin
// grant and a registered, owner-tagged result that supports one op per cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*(DATA_W+1)-1:0] req_in_a,
  input  logic [NUM_REQ*(DATA_W+1)-1:0] req_in_b,
  input  logic [NUM_REQ*OP_W-1:0]     req_alu_op,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]           resp_rd_val,
  output logic                        resp_lt,
  output logic                        resp_ltu,
  output logic                        resp_eq,
  output logic [DATA_W:0]             alu_in_a,
  output logic [DATA_W:0]             alu_in_b,
  output logic [OP_W-1:0]             alu_op,
  input  logic [DATA_W-1:0]           alu_rd_val_out,
  input  logic                        alu_lt,
  input  logic                        alu_ltu,
  input  logic                        alu_eq,
  output logic                        busy
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rd_val_q, rd_val_d;
  logic              lt_q, lt_d;
  logic              ltu_q, ltu_d;
  logic              eq_q, eq_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               can_issue;

  // A new op may issue when the result register is empty or is being drained.
  assign can_issue   = (state_q == ARB_IDLE) || resp_ready[owner_q];
  assign grant_valid = |grant;
  assign req_ready   = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (can_issue && !reset),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    alu_in_a = '0;
    alu_in_b = '0;
    alu_op   = '0;
    if (grant_valid) begin
      alu_in_a = req_in_a[grant_idx*(DATA_W+1) +: (DATA_W+1)];
      alu_in_b = req_in_b[grant_idx*(DATA_W+1) +: (DATA_W+1)];
      alu_op   = req_alu_op[grant_idx*OP_W +: OP_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rd_val_d     = rd_val_q;
    lt_d         = lt_q;
    ltu_d        = ltu_q;
    eq_d         = eq_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (resp_ready[owner_q] && !grant_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (grant_valid) begin
      owner_d      = grant_idx;
      last_grant_d = grant_idx;
      rd_val_d     = alu_rd_val_out;
      lt_d         = alu_lt;
      ltu_d        = alu_ltu;
      eq_d         = alu_eq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rd_val_q     <= '0;
      lt_q         <= 1'b0;
      ltu_q        <= 1'b0;
      eq_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rd_val_q     <= rd_val_d;
      lt_q         <= lt_d;
      ltu_q        <= ltu_d;
      eq_q         <= eq_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == ARB_RESP) resp_valid[owner_q] = 1'b1;
  end

  assign resp_rd_val = rd_val_q;
  assign resp_lt     = lt_q;
  assign resp_ltu    = ltu_q;
  assign resp_eq     = eq_q;
  assign busy        = (state_q == ARB_RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a small ALU model feeds the DUT and a
// scoreboard holds the result each granted requester should receive.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 5;
  localparam int AW      = DATA_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              lt;
    logic              ltu;
    logic              eq;
  } alu_res_t;

  typedef struct packed {
    logic     owner;
    alu_res_t res;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [AW-1:0]           a0, b0, a1, b1;
  logic [OP_W-1:0]         op0, op1;
  logic [NUM_REQ*AW-1:0]   req_in_a, req_in_b;
  logic [NUM_REQ*OP_W-1:0] req_alu_op;
  logic [DATA_W-1:0]       resp_rd_val, alu_rd_val_out;
  logic                    resp_lt, resp_ltu, resp_eq;
  logic [AW-1:0]           alu_in_a, alu_in_b;
  logic [OP_W-1:0]         alu_op;
  logic                    alu_lt, alu_ltu, alu_eq, busy;
  alu_res_t                alu_res;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  assign req_in_a   = {a1, a0};
  assign req_in_b   = {b1, b0};
  assign req_alu_op = {op1, op0};

  always #5 clk = ~clk;

  function automatic alu_res_t alu_model(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                         input logic [OP_W-1:0] op);
    alu_res_t r;
    r.lt  = $signed(a) < $signed(b);
    r.ltu = a[DATA_W-1:0] < b[DATA_W-1:0];
    r.eq  = (a == b);
    case (op)
      ALU_ADD:  r.val = a[DATA_W-1:0] + b[DATA_W-1:0];
      ALU_SUB:  r.val = a[DATA_W-1:0] - b[DATA_W-1:0];
      ALU_AND:  r.val = a[DATA_W-1:0] & b[DATA_W-1:0];
      ALU_OR:   r.val = a[DATA_W-1:0] | b[DATA_W-1:0];
      ALU_XOR:  r.val = a[DATA_W-1:0] ^ b[DATA_W-1:0];
      ALU_SLT:  r.val = {{(DATA_W-1){1'b0}}, r.lt};
      ALU_SLTU: r.val = {{(DATA_W-1){1'b0}}, r.ltu};
      default:  r.val = '0;
    endcase
    return r;
  endfunction

  assign alu_res        = alu_model(alu_in_a, alu_in_b, alu_op);
  assign alu_rd_val_out = alu_res.val;
  assign alu_lt         = alu_res.lt;
  assign alu_ltu        = alu_res.ltu;
  assign alu_eq         = alu_res.eq;

  alu_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .OP_W    (OP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_in_a       (req_in_a),
    .req_in_b       (req_in_b),
    .req_alu_op     (req_alu_op),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rd_val    (resp_rd_val),
    .resp_lt        (resp_lt),
    .resp_ltu       (resp_ltu),
    .resp_eq        (resp_eq),
    .alu_in_a       (alu_in_a),
    .alu_in_b       (alu_in_b),
    .alu_op         (alu_op),
    .alu_rd_val_out (alu_rd_val_out),
    .alu_lt         (alu_lt),
    .alu_ltu        (alu_ltu),
    .alu_eq         (alu_eq),
    .busy           (busy)
  );

  // Inputs change just after the falling edge and hold through the next rising
  // edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [1:0] v, input logic [1:0] rr,
                       input logic [AW-1:0] ia0, input logic [AW-1:0] ib0, input logic [OP_W-1:0] iop0,
                       input logic [AW-1:0] ia1, input logic [AW-1:0] ib1, input logic [OP_W-1:0] iop1);
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr;
    a0 = ia0; b0 = ib0; op0 = iop0;
    a1 = ia1; b1 = ib1; op1 = iop1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b00, 33'd1, 33'd2, ALU_ADD, 33'd3, 33'd4, ALU_ADD);
      checks++;
      if ({req_ready, resp_valid, resp_rd_val, busy} !== {2'b00, 2'b00, 32'd0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got rdy=%b rv=%b val=%h busy=%b want 00 00 0 0",
                 req_ready, resp_valid, resp_rd_val, busy);
      end
    end
    reset     = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single_op;
    drive(2'b01, 2'b00, 33'd5, 33'd7, ALU_ADD, '0, '0, ALU_NONE);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL single_grant: got %b want 01", req_ready);
    end
    e.owner = 1'b0; e.res = '{val: 32'd12, lt: 1'b1, ltu: 1'b1, eq: 1'b0};
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
      checks++;
      if ({resp_valid, resp_rd_val, busy, req_ready} !== {2'b01, 32'd12, 1'b1, 2'b00}) begin
        failures++;
        $display("[TB] FAIL single_hold: got rv=%b val=%0d busy=%b rdy=%b want 01 12 1 00",
                 resp_valid, resp_rd_val, busy, req_ready);
      end
    end
    drive(2'b00, 2'b01, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL single_sb: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== (2'b01 << e.owner) || {resp_rd_val, resp_lt, resp_ltu, resp_eq} !== e.res) begin
        failures++;
        $display("[TB] FAIL single_result: got rv=%b res=%h want rv=%b res=%h",
                 resp_valid, {resp_rd_val, resp_lt, resp_ltu, resp_eq}, 2'b01 << e.owner, e.res);
      end
    end
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if ({resp_valid, busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL single_drain: got rv=%b busy=%b want 00 0", resp_valid, busy);
    end
  endtask

  task automatic test_contention;
    logic          exp_g;
    logic [AW-1:0] ga, gb;
    logic [OP_W-1:0] gop;
    // Requester 0 was the last winner, so requester 1 leads the alternation.
    exp_g = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 2'b11, AW'(i), 33'd100, ALU_ADD, 33'd1000, AW'(i), ALU_SUB);
      checks++;
      if (req_ready !== (2'b01 << exp_g)) begin
        failures++;
        $display("[TB] FAIL contention_grant[%0d]: got %b want %b", i, req_ready, 2'b01 << exp_g);
      end
      if (i > 0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL contention_sb[%0d]: got empty scoreboard want 1 entry", i);
        end else begin
          e = sb.pop_front();
          if (resp_valid !== (2'b01 << e.owner) || {resp_rd_val, resp_lt, resp_ltu, resp_eq} !== e.res) begin
            failures++;
            $display("[TB] FAIL contention_result[%0d]: got rv=%b res=%h want rv=%b res=%h", i,
                     resp_valid, {resp_rd_val, resp_lt, resp_ltu, resp_eq}, 2'b01 << e.owner, e.res);
          end
        end
      end
      ga  = exp_g ? 33'd1000 : AW'(i);
      gb  = exp_g ? AW'(i) : 33'd100;
      gop = exp_g ? ALU_SUB : ALU_ADD;
      e.owner = exp_g;
      e.res   = alu_model(ga, gb, gop);
      sb.push_back(e);
      exp_g = ~exp_g;
    end
    drive(2'b00, 2'b11, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL contention_tail_sb: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== (2'b01 << e.owner) || {resp_rd_val, resp_lt, resp_ltu, resp_eq} !== e.res) begin
        failures++;
        $display("[TB] FAIL contention_tail: got rv=%b res=%h want rv=%b res=%h",
                 resp_valid, {resp_rd_val, resp_lt, resp_ltu, resp_eq}, 2'b01 << e.owner, e.res);
      end
    end
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL contention_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_compare_flags;
    drive(2'b10, 2'b00, '0, '0, ALU_NONE, 33'h1_FFFF_FFFF, 33'd1, ALU_SLT);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL flags_grant: got %b want 10", req_ready);
    end
    e.owner = 1'b1; e.res = '{val: 32'd1, lt: 1'b1, ltu: 1'b0, eq: 1'b0};
    sb.push_back(e);
    // resp_ready from the non-owner must not release the result.
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 2'b01, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
      checks++;
      if ({resp_valid, resp_lt, resp_ltu, resp_eq} !== {2'b10, 3'b100}) begin
        failures++;
        $display("[TB] FAIL flags_hold[%0d]: got rv=%b lt/ltu/eq=%b%b%b want 10 100", i,
                 resp_valid, resp_lt, resp_ltu, resp_eq);
      end
    end
    drive(2'b00, 2'b10, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL flags_sb: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== (2'b01 << e.owner) || {resp_rd_val, resp_lt, resp_ltu, resp_eq} !== e.res) begin
        failures++;
        $display("[TB] FAIL flags_result: got rv=%b res=%h want rv=%b res=%h",
                 resp_valid, {resp_rd_val, resp_lt, resp_ltu, resp_eq}, 2'b01 << e.owner, e.res);
      end
    end
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
  endtask

  task automatic test_back_pressure;
    drive(2'b01, 2'b00, 33'd3, 33'd4, ALU_ADD, '0, '0, ALU_NONE);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_first_grant: got %b want 01", req_ready);
    end
    e.owner = 1'b0; e.res = '{val: 32'd7, lt: 1'b1, ltu: 1'b1, eq: 1'b0};
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 2'b00, '0, '0, ALU_NONE, 33'd9, 33'd2, ALU_OR);
      checks++;
      if ({req_ready, resp_valid} !== {2'b00, 2'b01}) begin
        failures++;
        $display("[TB] FAIL bp_stall[%0d]: got rdy=%b rv=%b want 00 01", i, req_ready, resp_valid);
      end
    end
    drive(2'b10, 2'b01, '0, '0, ALU_NONE, 33'd9, 33'd2, ALU_OR);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL bp_release_grant: got %b want 10", req_ready);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL bp_sb0: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== (2'b01 << e.owner) || {resp_rd_val, resp_lt, resp_ltu, resp_eq} !== e.res) begin
        failures++;
        $display("[TB] FAIL bp_result0: got rv=%b res=%h want rv=%b res=%h",
                 resp_valid, {resp_rd_val, resp_lt, resp_ltu, resp_eq}, 2'b01 << e.owner, e.res);
      end
    end
    e.owner = 1'b1; e.res = '{val: 32'd11, lt: 1'b0, ltu: 1'b0, eq: 1'b0};
    sb.push_back(e);
    drive(2'b00, 2'b10, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL bp_sb1: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== (2'b01 << e.owner) || {resp_rd_val, resp_lt, resp_ltu, resp_eq} !== e.res) begin
        failures++;
        $display("[TB] FAIL bp_result1: got rv=%b res=%h want rv=%b res=%h",
                 resp_valid, {resp_rd_val, resp_lt, resp_ltu, resp_eq}, 2'b01 << e.owner, e.res);
      end
    end
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
  endtask

  task automatic test_reset_mid_resp;
    drive(2'b10, 2'b00, '0, '0, ALU_NONE, 33'd20, 33'd22, ALU_ADD);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rst_mid_grant: got %b want 10", req_ready);
    end
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if ({resp_valid, resp_rd_val, busy} !== {2'b10, 32'd42, 1'b1}) begin
      failures++;
      $display("[TB] FAIL rst_mid_pending: got rv=%b val=%0d busy=%b want 10 42 1",
               resp_valid, resp_rd_val, busy);
    end
    reset = 1'b1;
    drive(2'b11, 2'b00, 33'd1, 33'd1, ALU_ADD, 33'd2, 33'd2, ALU_ADD);
    checks++;
    if ({req_ready, resp_valid} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rst_mid_cleared: got rdy=%b rv=%b want 00 00", req_ready, resp_valid);
    end
    reset     = 1'b0;
    req_valid = 2'b00;
    sb.delete();
    drive(2'b11, 2'b00, 33'd1, 33'd1, ALU_ADD, 33'd2, 33'd2, ALU_ADD);
    checks++;
    if ({req_ready, resp_valid, resp_rd_val, resp_lt, resp_ltu, resp_eq, busy} !==
        {2'b01, 2'b00, 32'd0, 3'b000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL rst_mid_after: got rdy=%b rv=%b val=%h flags=%b%b%b busy=%b want 01 00 0 000 0",
               req_ready, resp_valid, resp_rd_val, resp_lt, resp_ltu, resp_eq, busy);
    end
    // Requester 0 now owns the result, so without a pointer reset requester 1 would win next.
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    checks++;
    if (resp_valid !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rst_mid_owner0: got %b want 01", resp_valid);
    end
    reset = 1'b1;
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    reset     = 1'b0;
    req_valid = 2'b00;
    drive(2'b11, 2'b00, 33'd1, 33'd1, ALU_ADD, 33'd2, 33'd2, ALU_ADD);
    checks++;
    if ({req_ready, resp_valid} !== {2'b01, 2'b00}) begin
      failures++;
      $display("[TB] FAIL rst_pointer: got rdy=%b rv=%b want 01 00", req_ready, resp_valid);
    end
    drive(2'b00, 2'b01, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
    drive(2'b00, 2'b00, '0, '0, ALU_NONE, '0, '0, ALU_NONE);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    a0 = '0; b0 = '0; op0 = '0;
    a1 = '0; b1 = '0; op1 = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_compare_flags();
    test_back_pressure();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
